ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. Sends command bytes from the CPU to the keyboard on PS2_CLK/PS2_DAT, e.g. 0xED set-LEDs or 0xFF reset. This is the opposite direction of the keyboard receive path.
- Byte write uses io_interface-style strobes.
- The block drives both PS/2 lines open-drain through active-high pull-low enables.
- Completion or failure raises irq, which the CPU clears with reset_irq.

---
 rtl/ps2_host_tx.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// The CPU writes one command byte. The block inhibits the bus, requests
// to send, and shifts out the data bits, parity and stop bit on the
// device-generated clock. It then samples the device ACK.
// Both PS/2 lines are driven open-drain through registered pull-low
// enables, so the pins never glitch.
// Optional feature macro: PS2_TX_RETRY_EN. When it is defined, a NACK or
// a timeout restarts the transfer from INHIBIT, with at most 2 retries.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned START_TIMEOUT  = 750000,
   parameter int unsigned XFER_TIMEOUT   = 100000,
   parameter int unsigned CNT_W          = 20
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       wenable,
   input  logic [7:0] wdata,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic [1:0] status,
   output logic       irq,
   input  logic       reset_irq
);

   localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_TO  = CNT_W'(START_TIMEOUT);
   localparam logic [CNT_W-1:0] XFER_TO   = CNT_W'(XFER_TIMEOUT);
   localparam logic [CNT_W-1:0] TIMER_MAX = '1;

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_NACK     = 2'b01;
   localparam logic [1:0] ST_START_TO = 2'b10;
   localparam logic [1:0] ST_XFER_TO  = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_WAIT_CLK,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE,
      S_DONE,
      S_FAIL
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
   logic [7:0]       byte_q, byte_d;
   logic             parity_q, parity_d;
   logic [8:0]       shift_q, shift_d;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [1:0]       status_q, status_d;
   logic             irq_q, irq_d;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]       retry_q, retry_d;
`endif

   // Synchronizer stages and the previous synced clock for edge detection.
   logic clk_meta_q, clk_sync_q, clk_prev_q;
   logic dat_meta_q, dat_sync_q;
   logic clk_fall;
   logic fail_hit;
   logic [1:0] fail_code;

   // Two-flop synchronizers on both raw pins plus a delayed copy of the synced clock.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         clk_meta_q <= 1'b0;
         clk_sync_q <= 1'b0;
         clk_prev_q <= 1'b0;
         dat_meta_q <= 1'b0;
         dat_sync_q <= 1'b0;
      end else begin
         clk_meta_q <= ps2_clk_in;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         dat_meta_q <= ps2_dat_in;
         dat_sync_q <= dat_meta_q;
      end
   end

   // A single-cycle falling-edge flag. Each device clock edge can only be counted once.
   assign clk_fall  = clk_prev_q & ~clk_sync_q;
   // The timer saturates so that a stuck bus can never wrap back under a timeout.
   assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;

   // Next-state logic and datapath updates. Every registered output is computed here.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      byte_d    = byte_q;
      parity_d  = parity_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      clk_oe_d  = clk_oe_q;
      dat_oe_d  = dat_oe_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      status_d  = status_q;
      fail_hit  = 1'b0;
      fail_code = ST_OK;
`ifdef PS2_TX_RETRY_EN
      retry_d   = retry_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (wenable) begin
               byte_d    = wdata;
               parity_d  = ~^wdata;
               busy_d    = 1'b1;
               clk_oe_d  = 1'b1;
               dat_oe_d  = 1'b0;
               timer_d   = '0;
               state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
               retry_d   = 2'd0;
`endif
            end
         end

         // Hold the clock low. Edges seen here come from our own pull-down and are ignored.
         S_INHIBIT: begin
            timer_d = timer_inc;
            if (timer_q >= INH_LAST) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b1;
               state_d  = S_REQ;
            end
         end

         // The start bit is on the line and the clock has been released. Load the frame.
         S_REQ: begin
            timer_d = '0;
            shift_d = {parity_q, byte_q};
            state_d = S_WAIT_CLK;
         end

         S_WAIT_CLK: begin
            timer_d = timer_inc;
            if (clk_fall) begin
               dat_oe_d  = ~shift_q[0];
               shift_d   = {1'b1, shift_q[8:1]};
               bit_idx_d = 4'd1;
               timer_d   = '0;
               state_d   = S_SHIFT;
            end else if (timer_q >= START_TO) begin
               fail_hit  = 1'b1;
               fail_code = ST_START_TO;
            end
         end

         // Edges 2..9 put data bits 1..7 and then parity on the line. Edge 10 releases data for the stop bit.
         S_SHIFT: begin
            timer_d = timer_inc;
            if (timer_q >= XFER_TO) begin
               fail_hit  = 1'b1;
               fail_code = ST_XFER_TO;
            end else if (clk_fall) begin
               if (bit_idx_q == 4'd9) begin
                  dat_oe_d = 1'b0;
                  state_d  = S_ACK;
               end else begin
                  dat_oe_d  = ~shift_q[0];
                  shift_d   = {1'b1, shift_q[8:1]};
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
         end

         S_ACK: begin
            timer_d = timer_inc;
            if (timer_q >= XFER_TO) begin
               fail_hit  = 1'b1;
               fail_code = ST_XFER_TO;
            end else if (clk_fall) begin
               if (!dat_sync_q) begin
                  status_d = ST_OK;
                  state_d  = S_WAIT_IDLE;
               end else begin
                  fail_hit  = 1'b1;
                  fail_code = ST_NACK;
               end
            end
         end

         S_WAIT_IDLE: begin
            if (clk_sync_q && dat_sync_q) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end

         // One-cycle done states. busy drops on the following cycle.
         S_DONE, S_FAIL: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
         end
      endcase

      // Any failure releases the bus. It either retries or finishes at once.
      if (fail_hit) begin
         clk_oe_d = 1'b0;
         dat_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
         if (retry_q < 2'd2) begin
            retry_d  = retry_q + 2'd1;
            clk_oe_d = 1'b1;
            timer_d  = '0;
            state_d  = S_INHIBIT;
         end else begin
            status_d = fail_code;
            done_d   = 1'b1;
            state_d  = S_FAIL;
         end
`else
         status_d = fail_code;
         done_d   = 1'b1;
         state_d  = S_FAIL;
`endif
      end
   end

   // irq rises on the same edge as done. A simultaneous clear loses to the set.
   assign irq_d = done_d | (irq_q & ~reset_irq);

   // State and datapath registers. The asynchronous reset releases both lines immediately.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         byte_q    <= 8'h00;
         parity_q  <= 1'b0;
         shift_q   <= 9'h000;
         bit_idx_q <= 4'd0;
         clk_oe_q  <= 1'b0;
         dat_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         status_q  <= 2'b00;
         irq_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retry_q   <= 2'd0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         byte_q    <= byte_d;
         parity_q  <= parity_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         clk_oe_q  <= clk_oe_d;
         dat_oe_q  <= dat_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         status_q  <= status_d;
         irq_q     <= irq_d;
`ifdef PS2_TX_RETRY_EN
         retry_q   <= retry_d;
`endif
      end
   end

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign status     = status_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx. A behavioural PS/2 device model responds on
// the open-drain bus. The stimulus pushes the hand-computed expected
// results into a scoreboard queue. A monitor pops and compares them on
// every done pulse.
module tb_ps2_host_tx;

   localparam int INH      = 40;
   localparam int START_TO = 300;
   localparam int XFER_TO  = 400;
`ifdef PS2_TX_RETRY_EN
   localparam int FAIL_PHASES = 3;
`else
   localparam int FAIL_PHASES = 1;
`endif

   localparam int DEV_ACK    = 0;
   localparam int DEV_NACK   = 1;
   localparam int DEV_SILENT = 2;
   localparam int DEV_STOP5  = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       wenable;
   logic [7:0] wdata;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       busy, done, irq, reset_irq;
   logic [1:0] status;

   // Open-drain bus with pull-ups. The device pulls the lines low through dev_*_low.
   logic dev_clk_low, dev_dat_low;
   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .START_TIMEOUT (START_TO),
      .XFER_TIMEOUT  (XFER_TO),
      .CNT_W         (20)
   ) dut (
      .CLOCK_50  (clk),
      .reset     (reset),
      .wenable   (wenable),
      .wdata     (wdata),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .busy      (busy),
      .done      (done),
      .status    (status),
      .irq       (irq),
      .reset_irq (reset_irq)
   );

   typedef struct packed {
      logic [1:0] status;
      logic       chk_cap;
      logic [9:0] cap;      // {stop, parity, data[7:0]}
      logic [3:0] phases;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int done_seen = 0;
   int done_cyc = 0;
   int release_cyc = 0;
   int dev_fall1_cyc = 0;
   int dev_mode = DEV_ACK;
   bit dev_nack_once = 1'b0;
   bit dev_active = 1'b0;
   int dev_edges = 0;
   logic [9:0] dev_cap = '0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
   endtask

   task automatic push_exp(input logic [1:0] st, input logic chk, input logic [9:0] cap,
                           input int phases);
      exp_t e;
      e.status  = st;
      e.chk_cap = chk;
      e.cap     = cap;
      e.phases  = 4'(phases);
      exp_q.push_back(e);
   endtask

   task automatic write_byte(input logic [7:0] b);
      @(negedge clk);
      wdata   = b;
      wenable = 1'b1;
      @(negedge clk);
      wenable = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int start;
      bit got;
      start = done_seen;
      got   = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (done_seen != start) got = 1'b1;
      end
      check("done_within_budget", int'(got), 1);
      repeat (2) @(negedge clk);
   endtask

   // Device model. It answers each host request with up to 11 clock pulses,
   // samples data on each rising edge and pulls data low for the ACK.
   initial begin
      bit nack_now;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      forever begin
         wait (ps2_clk_oe == 1'b1);
         wait (ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1);
         if (dev_mode == DEV_SILENT) continue;
         nack_now      = (dev_mode == DEV_NACK) || dev_nack_once;
         dev_nack_once = 1'b0;
         dev_active    = 1'b1;
         dev_edges     = 0;
         dev_cap       = '0;
         repeat (20) @(negedge clk);
         for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            dev_edges   = k;
            if (k == 1) dev_fall1_cyc = cyc;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) dev_cap[k-1] = ps2_dat_in;
            if (k == 10 && !nack_now) dev_dat_low = 1'b1;
            repeat (10) @(negedge clk);
            if (k == 5 && dev_mode == DEV_STOP5) break;
         end
         dev_dat_low = 1'b0;
         dev_active  = 1'b0;
      end
   end

   // Monitor: measures the inhibit phases, and on every done pops the scoreboard and compares.
   initial begin
      int   inh_run;
      int   inh_phases;
      bit   prev_done;
      exp_t e;
      inh_run    = 0;
      inh_phases = 0;
      prev_done  = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            inh_run    = 0;
            inh_phases = 0;
            prev_done  = 1'b0;
         end else begin
            if (prev_done) begin
               check("busy_after_done", int'(busy), 0);
               check("done_one_cycle", int'(done), 0);
            end
            prev_done = done;
            if (ps2_clk_oe) begin
               inh_run++;
            end else if (inh_run != 0) begin
               check("inhibit_len", inh_run, INH);
               inh_phases++;
               inh_run     = 0;
               release_cyc = cyc;
            end
            if (done) begin
               done_cyc = cyc;
               done_seen++;
               check("expected_pending", int'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("status", int'(status), int'(e.status));
                  check("irq_with_done", int'(irq), 1);
                  check("busy_at_done", int'(busy), 1);
                  check("lines_released", int'({ps2_clk_oe, ps2_dat_oe}), 0);
                  check("inhibit_phases", inh_phases, int'(e.phases));
                  if (e.chk_cap) check("device_frame", int'(dev_cap), int'(e.cap));
                  $display("txn %0d status=%b frame=%h phases=%0d cyc=%0d",
                           done_seen, status, dev_cap, inh_phases, cyc);
               end
               inh_phases = 0;
            end
         end
      end
   end

   // Directed vectors: byte and hand-computed frame {stop, odd parity, byte}.
   logic [7:0] vec_byte [3];
   logic [9:0] vec_cap  [3];

   initial begin
      vec_byte[0] = 8'hED; vec_cap[0] = {1'b1, 1'b1, 8'hED};
      vec_byte[1] = 8'hF4; vec_cap[1] = {1'b1, 1'b0, 8'hF4};
      vec_byte[2] = 8'h00; vec_cap[2] = {1'b1, 1'b1, 8'h00};

      reset     = 1'b1;
      wenable   = 1'b0;
      wdata     = 8'h00;
      reset_irq = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", int'({ps2_clk_oe, ps2_dat_oe, busy, done, status, irq}), 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Successful transfers with the device ACKing.
      dev_mode = DEV_ACK;
      for (int i = 0; i < 3; i++) begin
         push_exp(2'b00, 1'b1, vec_cap[i], 1);
         write_byte(vec_byte[i]);
         wait_done(2000);
      end

      // The device never clocks, so the start timeout fires. Then reset_irq clears irq.
      @(negedge clk); reset_irq = 1'b1;
      @(negedge clk); reset_irq = 1'b0;
      check("irq_cleared_before", int'(irq), 0);
      dev_mode = DEV_SILENT;
      push_exp(2'b10, 1'b0, 10'h000, FAIL_PHASES);
      write_byte(8'hA5);
      wait_done(5000);
      check_range("start_timeout_latency", done_cyc - release_cyc, START_TO, START_TO + 2);
      check("irq_sticky", int'(irq), 1);
      @(negedge clk); reset_irq = 1'b1;
      @(negedge clk); reset_irq = 1'b0;
      check("irq_cleared", int'(irq), 0);

      // NACK: the device leaves data high at the ACK edge.
      dev_mode = DEV_NACK;
      push_exp(2'b01, 1'b1, {1'b1, 1'b1, 8'h3C}, FAIL_PHASES);
      write_byte(8'h3C);
      wait_done(5000);

      // Transfer timeout: the device stops clocking after edge 5.
      dev_mode = DEV_STOP5;
      push_exp(2'b11, 1'b0, 10'h000, FAIL_PHASES);
      write_byte(8'h81);
      wait_done(5000);
      check_range("xfer_timeout_latency", done_cyc - dev_fall1_cyc, XFER_TO, XFER_TO + 6);

      // A write while busy is ignored and the original byte completes.
      dev_mode = DEV_ACK;
      push_exp(2'b00, 1'b1, {1'b1, 1'b1, 8'h96}, 1);
      write_byte(8'h96);
      repeat (5) @(negedge clk);
      check("busy_in_inhibit", int'(busy), 1);
      write_byte(8'h55);
      wait_done(2000);

      // Reset mid-SHIFT while data bit 3 (0) is driven: lines release asynchronously.
      write_byte(8'h52);
      for (int i = 0; i < 2000 && !(dev_active && dev_edges >= 4); i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("pre_reset_drive", int'({ps2_clk_oe, ps2_dat_oe, busy}), 3'b011);
      #2 reset = 1'b1;
      #1 check("async_release", int'({ps2_clk_oe, ps2_dat_oe, busy}), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2000 && dev_active; i++) @(negedge clk);
      check("device_idle_after_reset", int'(dev_active), 0);
      repeat (5) @(negedge clk);
      push_exp(2'b00, 1'b1, {1'b1, 1'b1, 8'hED}, 1);
      write_byte(8'hED);
      wait_done(2000);

`ifdef PS2_TX_RETRY_EN
      // The first attempt is NACKed and the retry is ACKed: one done, two inhibit phases.
      dev_nack_once = 1'b1;
      push_exp(2'b00, 1'b1, {1'b1, 1'b0, 8'hA7}, 2);
      write_byte(8'hA7);
      wait_done(4000);
`endif

      repeat (10) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
